led_frame_buffer: RTL and testbench

//   Parametrised double-buffered (ping-pong) LED frame store, successor to the single-bank RAM.
//   Two banks of DEPTH words. The protocol side writes the back bank; the LED driver reads the front bank.
//   A swap request exchanges the banks at a safe cycle, so the driver never sees a half-written frame.

---
 rtl/led_pkg.sv | 10 +
 rtl/led_dpram.sv | 31 +++
 rtl/led_frame_buffer.sv | 104 ++++++++++
 tb/tb_led_frame_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and swap-FSM state encoding for the LED frame buffer.
package led_pkg;
  localparam int LED_DATA_WIDTH = 8;
  localparam int LED_ADDR_WIDTH = 9;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_e;
endpackage

// File: rtl/led_dpram.sv
// Simple dual-port RAM: one write port, one registered read port (iCE40 block RAM style).
module led_dpram
  import led_pkg::*;
#(
  parameter int DATA_WIDTH = LED_DATA_WIDTH,
  parameter int ADDR_WIDTH = LED_ADDR_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_en_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (write_en_i) mem_q[write_addr_i] <= write_data_i;
  end

  // Read register only loads on a request, so the last result is held.
  always_ff @(posedge clock) begin
    if (reset) rdata_q <= '0;
    else if (read_en_i) rdata_q <= mem_q[read_addr_i];
  end

  assign read_data_o = rdata_q;
endmodule

// File: rtl/led_frame_buffer.sv
// Ping-pong LED frame store: bank select, swap FSM and read-valid pipeline.
// Define READ_REGISTER_EN to add an output register (read latency 2 instead of 1).
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int DATA_WIDTH = LED_DATA_WIDTH,
  parameter int ADDR_WIDTH = LED_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  perform_read,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_data_ready,
  input  logic                  perform_write,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  swap_request,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  front_bank
);
  swap_state_e           state_q, state_d;
  logic                  front_q, front_d;
  logic                  swap_done_q, swap_done_d;
  logic                  vld_p0;
  logic                  in_flight;
  logic [DATA_WIDTH-1:0] ram_rdata;

  led_dpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH + 1)
  ) u_ram (
    .clock       (clock),
    .reset       (reset),
    .read_en_i   (perform_read),
    .read_addr_i ({front_q, read_address}),
    .read_data_o (ram_rdata),
    .write_en_i  (perform_write),
    .write_addr_i({~front_q, write_address}),
    .write_data_i(write_data)
  );

  // Stage 0: RAM read register
  always_ff @(posedge clock) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= perform_read;
  end

`ifdef READ_REGISTER_EN
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] rdata_p1;

  // Stage 1: output register
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) rdata_p1 <= ram_rdata;
    end
  end

  assign in_flight       = vld_p0 | vld_p1;
  assign read_data       = rdata_p1;
  assign read_data_ready = vld_p1;
`else
  assign in_flight       = vld_p0;
  assign read_data       = ram_rdata;
  assign read_data_ready = vld_p0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      swap_done_q <= swap_done_d;
    end
  end

  // Toggle only when no read is being issued or still draining from the old front bank.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    swap_done_d = 1'b0;
    case (state_q)
      ST_IDLE:    if (swap_request) state_d = ST_PENDING;
      ST_PENDING: if (!perform_read && !in_flight) begin
        state_d     = ST_IDLE;
        front_d     = ~front_q;
        swap_done_d = 1'b1;
      end
    endcase
  end

  assign swap_pending = (state_q == ST_PENDING);
  assign swap_done    = swap_done_q;
  assign front_bank   = front_q;
endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer; expected read latency follows READ_REGISTER_EN.
module tb_led_frame_buffer;
`ifdef READ_REGISTER_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int OP_W = 0, OP_R = 1, OP_SW = 2, OP_RW = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       perform_read = 1'b0;
  logic [8:0] read_address = '0;
  logic [7:0] read_data;
  logic       read_data_ready;
  logic       perform_write = 1'b0;
  logic [8:0] write_address = '0;
  logic [7:0] write_data = '0;
  logic       swap_request = 1'b0;
  logic       swap_pending;
  logic       swap_done;
  logic       front_bank;

  int total = 0;
  int bad = 0;

  led_frame_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .perform_read   (perform_read),
    .read_address   (read_address),
    .read_data      (read_data),
    .read_data_ready(read_data_ready),
    .perform_write  (perform_write),
    .write_address  (write_address),
    .write_data     (write_data),
    .swap_request   (swap_request),
    .swap_pending   (swap_pending),
    .swap_done      (swap_done),
    .front_bank     (front_bank)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         op;
    logic [8:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clock);
    perform_write = 1'b1; write_address = a; write_data = d;
    @(negedge clock);
    perform_write = 1'b0;
  endtask

  // Ready must appear exactly L cycles after the request and last one cycle.
  task automatic do_read(input logic [8:0] a, input logic [7:0] exp,
                         input logic wr, input logic [7:0] wd);
    @(negedge clock);
    perform_read = 1'b1; read_address = a;
    perform_write = wr; write_address = a; write_data = wd;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clock);
      if (k == 1) begin
        perform_read = 1'b0; perform_write = 1'b0;
      end
      chk($sformatf("ready_lat_k%0d", k), read_data_ready, (k == L));
      if (k == L) chk("read_data", read_data, exp);
    end
  endtask

  task automatic do_swap(input logic exp_front);
    int n;
    @(negedge clock);
    swap_request = 1'b1;
    @(negedge clock);
    swap_request = 1'b0;
    chk("swap_pending_set", swap_pending, 1);
    n = 0;
    while (!swap_done && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("swap_done_seen", swap_done, 1);
    chk("front_after_swap", front_bank, exp_front);
    chk("pending_cleared", swap_pending, 0);
    @(negedge clock);
    chk("swap_done_pulse", swap_done, 0);
  endtask

  initial begin
    int nrdy;
    int ndone;

    vecs[0]  = '{OP_W,  9'h003, 8'h11, 8'h00};
    vecs[1]  = '{OP_W,  9'h1FF, 8'h22, 8'h00};
    vecs[2]  = '{OP_SW, 9'h000, 8'h00, 8'h01};
    vecs[3]  = '{OP_W,  9'h003, 8'h33, 8'h00};
    vecs[4]  = '{OP_W,  9'h1FF, 8'h44, 8'h00};
    vecs[5]  = '{OP_SW, 9'h000, 8'h00, 8'h00};
    vecs[6]  = '{OP_W,  9'h003, 8'hA5, 8'h00};
    vecs[7]  = '{OP_R,  9'h003, 8'h00, 8'h33};
    vecs[8]  = '{OP_SW, 9'h000, 8'h00, 8'h01};
    vecs[9]  = '{OP_R,  9'h003, 8'h00, 8'hA5};
    vecs[10] = '{OP_RW, 9'h1FF, 8'h3C, 8'h22};
    vecs[11] = '{OP_SW, 9'h000, 8'h00, 8'h00};
    vecs[12] = '{OP_R,  9'h1FF, 8'h00, 8'h3C};
    vecs[13] = '{OP_R,  9'h003, 8'h00, 8'h33};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_front", front_bank, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_done", swap_done, 0);
    chk("rst_ready", read_data_ready, 0);
    chk("rst_data", read_data, 0);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_W:  do_write(vecs[i].addr, vecs[i].data);
        OP_R:  do_read(vecs[i].addr, vecs[i].exp, 1'b0, 8'h00);
        OP_RW: do_read(vecs[i].addr, vecs[i].exp, 1'b1, vecs[i].data);
        default: do_swap(vecs[i].exp[0]);
      endcase
    end

    // Burst of reads with a swap request mid-burst; front is 0 holding 0x33 @3.
    nrdy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (read_data_ready) begin
        nrdy++;
        chk("burst_data", read_data, 8'h33);
      end
      if (c >= 2) begin
        chk("burst_pending", swap_pending, 1);
        chk("burst_front", front_bank, 0);
      end
      perform_read = 1'b1; read_address = 9'h003; swap_request = (c == 1);
    end
    @(negedge clock);
    if (read_data_ready) begin
      nrdy++;
      chk("burst_data", read_data, 8'h33);
    end
    chk("burst_pending_end", swap_pending, 1);
    perform_read = 1'b0;
    for (int j = 1; j <= L + 2; j++) begin
      @(negedge clock);
      if (read_data_ready) begin
        nrdy++;
        chk("burst_data", read_data, 8'h33);
      end
      chk($sformatf("burst_front_j%0d", j), front_bank, (j >= L + 1));
      chk($sformatf("burst_done_j%0d", j), swap_done, (j == L + 1));
      chk($sformatf("burst_pend_j%0d", j), swap_pending, (j < L + 1));
    end
    chk("burst_ready_count", nrdy, 6);

    // Repeated swap requests while pending yield a single toggle; front is 1 holding 0xA5 @3.
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (read_data_ready) chk("multi_data", read_data, 8'hA5);
      if (c >= 2) chk("multi_pending", swap_pending, 1);
      perform_read = 1'b1; read_address = 9'h003;
      swap_request = (c == 1 || c == 3 || c == 5);
    end
    @(negedge clock);
    perform_read = 1'b0; swap_request = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      if (swap_done) ndone++;
    end
    chk("multi_done_count", ndone, 1);
    chk("multi_front", front_bank, 0);
    chk("multi_pending_clr", swap_pending, 0);

    // Reset while a swap is pending cancels it.
    do_swap(1'b1);
    @(negedge clock);
    perform_read = 1'b1; read_address = 9'h003; swap_request = 1'b1;
    @(negedge clock);
    swap_request = 1'b0;
    chk("pre_rst_pending", swap_pending, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_pending", swap_pending, 0);
    chk("mid_rst_front", front_bank, 0);
    chk("mid_rst_done", swap_done, 0);
    chk("mid_rst_ready", read_data_ready, 0);
    chk("mid_rst_data", read_data, 0);
    reset = 1'b0; perform_read = 1'b0;
    ndone = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      if (swap_done) ndone++;
      chk("post_rst_front", front_bank, 0);
    end
    chk("post_rst_done_count", ndone, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
